// File: rtl/relu_act_unit_if.sv
// ---------------------------------------------------------------------------
// relu_act_unit_if
// Purpose : streaming bus of the ReLU activation unit. It holds the input
//           beat channel (valid/ready/data/mode) and the output result
//           channel (valid/ready/data).
// Modports: master - the producer/consumer side (drives in_*, out_ready)
//           slave  - the activation unit (drives in_ready, out_valid, out_data)
// Params  : NBITS  lane width
//           NLANES lanes per beat; lane i lives at [i*NBITS +: NBITS]
// ---------------------------------------------------------------------------
interface relu_act_unit_if #(
    parameter int NBITS  = 16,
    parameter int NLANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NLANES*NBITS-1:0]  in_data;
    logic [1:0]               in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [NLANES*NBITS-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/relu_act_unit.sv
// ---------------------------------------------------------------------------
// relu_act_unit
// Purpose : 2-stage elastic activation pipeline. Each beat carries NLANES
//           signed fixed-point lanes and a 2-bit mode:
//             00 ReLU, 01 ReLU derivative, 10 leaky ReLU, 11 leaky derivative.
//           Stage 1 holds the accepted beat and its mode, stage 2 holds the
//           computed result that is presented downstream.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset
//           bus        relu_act_unit_if.slave (in_* beat in, out_* result out)
//           clr_stats  synchronous clear of neg_count      (RELU_STATS_EN only)
//           neg_count  saturating count of negative lanes  (RELU_STATS_EN only)
// Config  : define RELU_STATS_EN to build the negative-element counter.
// Params  : NBITS, FRAC, NLANES, LEAK_SHIFT (1..FRAC), CNT_W
// ---------------------------------------------------------------------------
module relu_act_unit #(
    parameter int NBITS      = 16,
    parameter int FRAC       = 8,
    parameter int NLANES     = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef RELU_STATS_EN
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     neg_count,
`endif
    relu_act_unit_if.slave       bus
);

    localparam int DW = NLANES * NBITS;

    // 1.0 in the lane format, and the leaky slope 2^-LEAK_SHIFT in the same format
    localparam logic [NBITS-1:0] ONE_VAL  = NBITS'(1) << FRAC;
    localparam logic [NBITS-1:0] LEAK_DER = NBITS'(1) << (FRAC - LEAK_SHIFT);

    // Per-lane activation. The leaky shift is done on a signed variable so
    // that it is an arithmetic shift (rounds toward -inf).
    function automatic logic [NBITS-1:0] f_act(
        input logic [NBITS-1:0] x,
        input logic [1:0]       mode
    );
        logic signed [NBITS-1:0] xs;
        logic signed [NBITS-1:0] sh;
        logic                    neg;
        logic [NBITS-1:0]        res;
        xs  = x;
        sh  = xs >>> LEAK_SHIFT;
        neg = x[NBITS-1];
        case (mode)
            2'b00:   res = neg ? {NBITS{1'b0}} : x;
            2'b01:   res = neg ? {NBITS{1'b0}} : ONE_VAL;
            2'b10:   res = neg ? sh            : x;
            2'b11:   res = neg ? LEAK_DER      : ONE_VAL;
            default: res = {NBITS{1'b0}};
        endcase
        return res;
    endfunction

    logic            r_s1_valid;
    logic [DW-1:0]   r_s1_data;
    logic [1:0]      r_s1_mode;
    logic            r_s2_valid;
    logic [DW-1:0]   r_s2_data;
    logic [DW-1:0]   w_result;
    logic            w_s2_loads;
    logic            w_in_ready;
    logic            w_in_fire;

    // s2 can take a new value whenever its current content leaves or it is empty;
    // in_ready is combinational from out_ready so a full pipe streams without bubbles
    assign w_s2_loads  = ~r_s2_valid | bus.out_ready;
    assign w_in_ready  = ~r_s1_valid | w_s2_loads;
    assign w_in_fire   = bus.in_valid & w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;

    // Activation of every lane held in stage 1
    always_comb begin
        w_result = {DW{1'b0}};
        for (int i = 0; i < NLANES; i++) begin
            w_result[i*NBITS +: NBITS] = f_act(r_s1_data[i*NBITS +: NBITS], r_s1_mode);
        end
    end

    // Stage 1: capture beat and mode on input handshake, empty when s2 drains it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DW{1'b0}};
            r_s1_mode  <= 2'b00;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= bus.in_data;
            r_s1_mode  <= bus.in_mode;
        end else if (w_s2_loads) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: register the result; data is held while the downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {DW{1'b0}};
        end else if (w_s2_loads) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_result;
            end else begin
                r_s2_data <= r_s2_data;
            end
        end else begin
            r_s2_valid <= r_s2_valid;
        end
    end

`ifdef RELU_STATS_EN
    localparam int NEG_W = $clog2(NLANES + 1);

    logic [NEG_W-1:0] w_neg_lanes;
    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] r_neg_count;

    // Number of negative lanes (MSB set) in the beat on the input bus
    always_comb begin
        w_neg_lanes = {NEG_W{1'b0}};
        for (int i = 0; i < NLANES; i++) begin
            w_neg_lanes = w_neg_lanes + NEG_W'(bus.in_data[i*NBITS + NBITS - 1]);
        end
    end

    // One extra bit catches the carry so the counter can saturate instead of wrapping
    assign w_cnt_sum = {1'b0, r_neg_count} + (CNT_W+1)'(w_neg_lanes);

    // Negative-element counter; clear has priority over a same-cycle handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_count <= {CNT_W{1'b0}};
        end else if (clr_stats) begin
            r_neg_count <= {CNT_W{1'b0}};
        end else if (w_in_fire) begin
            r_neg_count <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
        end else begin
            r_neg_count <= r_neg_count;
        end
    end

    assign neg_count = r_neg_count;
`endif

endmodule

// File: tb/tb_relu_act_unit.sv
// ---------------------------------------------------------------------------
// tb_relu_act_unit
// Directed bench for relu_act_unit at the default parameters. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Counter scenarios are built when RELU_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_relu_act_unit;

    logic clk;
    logic rst_n;
    logic clr_stats;
    logic [31:0] neg_count;

    relu_act_unit_if #(.NBITS(16), .NLANES(4)) bus ();

    relu_act_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RELU_STATS_EN
        .clr_stats (clr_stats),
        .neg_count (neg_count),
`endif
        .bus       (bus)
    );

`ifdef RELU_STATS_EN
    // Narrow-counter copy so that saturation is reachable in a few beats
    logic       clr2;
    logic [2:0] cnt2;
    relu_act_unit_if #(.NBITS(16), .NLANES(4)) bus2 ();
    relu_act_unit #(.CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_stats (clr2),
        .neg_count (cnt2),
        .bus       (bus2)
    );
`else
    assign neg_count = 32'd0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] rx_q[$];
    int          rx_cyc[$];
    int          acc_cyc[$];

    localparam logic [63:0] V1 = 64'hFF00_0280_0000_FFFF;
    localparam logic [63:0] V2 = 64'h8000_7FFF_0001_FFF8;

    // Hand-computed results: index = mode
    logic [63:0] exp_v1 [4] = '{64'h0000_0280_0000_0000, 64'h0000_0100_0100_0000,
                                64'hFFE0_0280_0000_FFFF, 64'h0020_0100_0100_0020};
    logic [63:0] exp_v2 [4] = '{64'h0000_7FFF_0001_0000, 64'h0000_0100_0100_0000,
                                64'hF000_7FFF_0001_FFFF, 64'h0020_0100_0100_0020};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output-handshake monitor (the handshake completes at the next rising edge)
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            rx_q.push_back(bus.out_data);
            rx_cyc.push_back(cyc);
        end
    end

    // Input-handshake monitor
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat until it is accepted; called and returns at posedge+1
    task automatic send(input logic [63:0] d, input logic [1:0] m, input logic clr);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        clr_stats    = clr;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr_stats    = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_stats     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'd0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b1;
`ifdef RELU_STATS_EN
        clr2           = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = 64'd0;
        bus2.in_mode   = 2'b00;
        bus2.out_ready = 1'b1;
`endif

        // ---- reset values ----
        idle(3);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_neg_count", {32'd0, neg_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // ---- the four modes on the reference vector ----
        rx_q.delete();
        for (int m = 0; m < 4; m++) send(V1, 2'(m), 1'b0);
        idle(4);
        chk("mode_count", 64'(rx_q.size()), 64'd4);
        for (int m = 0; m < 4 && m < rx_q.size(); m++)
            chk($sformatf("mode_%0d", m), rx_q[m], exp_v1[m]);

        // ---- 8-beat back-to-back stream, latency and throughput ----
        rx_q.delete();
        rx_cyc.delete();
        acc_cyc.delete();
        for (int b = 0; b < 8; b++) send((b < 4) ? V1 : V2, 2'(b % 4), 1'b0);
        idle(4);
        chk("stream_count", 64'(rx_q.size()), 64'd8);
        if (rx_q.size() == 8 && acc_cyc.size() >= 1) begin
            chk("stream_latency", 64'(rx_cyc[0] - acc_cyc[0]), 64'd2);
            chk("stream_back2back", 64'(rx_cyc[7] - rx_cyc[0]), 64'd7);
            for (int b = 0; b < 8; b++)
                chk($sformatf("stream_%0d", b), rx_q[b], (b < 4) ? exp_v1[b % 4] : exp_v2[b % 4]);
        end

        // ---- backpressure: out_ready low for 5 cycles ----
        rx_q.delete();
        bus.out_ready = 1'b0;
        send(V2, 2'b00, 1'b0);
        send(V2, 2'b10, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = V1;
        bus.in_mode  = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", k), {63'd0, bus.in_ready}, 64'd0);
            chk($sformatf("bp_out_valid_%0d", k), {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("bp_out_data_%0d", k), bus.out_data, exp_v2[0]);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(V1, 2'b11, 1'b0);
        idle(4);
        chk("bp_count", 64'(rx_q.size()), 64'd3);
        if (rx_q.size() == 3) begin
            chk("bp_beat0", rx_q[0], exp_v2[0]);
            chk("bp_beat1", rx_q[1], exp_v2[2]);
            chk("bp_beat2", rx_q[2], exp_v1[3]);
        end

`ifdef RELU_STATS_EN
        // ---- negative-element counter ----
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
        chk("cnt_clear", {32'd0, neg_count}, 64'd0);
        for (int k = 0; k < 3; k++) send(V1, 2'b00, 1'b0);
        @(negedge clk);
        chk("cnt_three_beats", {32'd0, neg_count}, 64'd6);
        @(posedge clk);
        #1;
        send(V1, 2'b00, 1'b1);
        @(negedge clk);
        chk("cnt_clear_wins", {32'd0, neg_count}, 64'd0);
        @(posedge clk);
        #1;

        // ---- saturation on the 3-bit counter copy ----
        bus2.in_data  = V1;
        bus2.in_valid = 1'b1;
        idle(3);
        chk("sat_six", {61'd0, cnt2}, 64'd6);
        idle(1);
        chk("sat_max", {61'd0, cnt2}, 64'd7);
        idle(1);
        chk("sat_hold", {61'd0, cnt2}, 64'd7);
        bus2.in_valid = 1'b0;
        idle(2);
`endif

        // ---- reset with two beats in flight ----
        bus.out_ready = 1'b0;
        send(V1, 2'b00, 1'b0);
        send(V1, 2'b10, 1'b0);
        @(negedge clk);
        chk("inflight_valid", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk);
        #1;
        rx_q.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_out_data", bus.out_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("postrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("postrst_neg_count", {32'd0, neg_count}, 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(4);
        chk("postrst_empty", 64'(rx_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
